// File: rtl/alu_result_reader_if.sv
// Bus bundle for alu_result_reader: ALU write-back port, host read command
// and the valid/ready result stream. The slave side is the reader block; the
// master side is whoever drives write-back, issues commands and consumes beats.
//   wr_en/wr_addr/wr_data            write-back into the result memory
//   cmd_valid/cmd_ready/start/count  read command handshake (count 0..2^ADDR_W)
//   out_valid/out_ready/data/addr/last  result stream
//   busy/done                        command status
interface alu_result_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_start;
  logic [ADDR_W:0]   cmd_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  wr_en, wr_addr, wr_data, cmd_valid, cmd_start, cmd_count, out_ready,
    output cmd_ready, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport master (
    output wr_en, wr_addr, wr_data, cmd_valid, cmd_start, cmd_count, out_ready,
    input  cmd_ready, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/alu_result_reader.sv
// alu_result_reader: owns the 2^ADDR_W x DATA_W result memory. Write-back
// writes every cycle it strobes; a host command streams a contiguous
// (mod 2^ADDR_W) address range out at up to one word per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_result_reader_if slave modport (write, command, stream, status)
// Read path: synchronous write-first memory read into rdata_q (the "in-flight"
// word), then a 2-entry output buffer. When the buffer is empty the in-flight
// word is presented directly so a full-rate stream has no extra latency.
module alu_result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_reader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              done_q, done_d;

  logic              rvld_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              rlast_q;

  logic [1:0][DATA_W-1:0] buf_data_q;
  logic [1:0][ADDR_W-1:0] buf_addr_q;
  logic [1:0]             buf_last_q;
  logic                   wp_q, rp_q;
  logic [1:0]             cnt_q;

  logic       out_valid, pop, rd_en, bypass, push, buf_pop;
  logic [1:0] occ;

  assign occ       = cnt_q + {1'b0, rvld_q};
  assign out_valid = (cnt_q != 2'd0) || rvld_q;
  assign pop       = out_valid && bus.out_ready;
  assign rd_en     = (state_q == READ) && (rem_q != '0) && (occ < 2'd2);
  // Empty buffer and the in-flight word taken straight from rdata_q.
  assign bypass    = (cnt_q == 2'd0) && rvld_q && pop;
  assign push      = rvld_q && !bypass;
  assign buf_pop   = pop && (cnt_q != 2'd0);

  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (cnt_q != 2'd0) ? buf_data_q[rp_q] : rdata_q;
  assign bus.out_addr  = (cnt_q != 2'd0) ? buf_addr_q[rp_q] : raddr_q;
  assign bus.out_last  = (cnt_q != 2'd0) ? buf_last_q[rp_q] : rlast_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        ptr_d = bus.cmd_start;
        rem_d = bus.cmd_count;
        // Empty command completes immediately without visiting READ.
        if (bus.cmd_count == '0) done_d  = 1'b1;
        else                     state_d = READ;
      end
      READ: if (rd_en) begin
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = rem_q - (ADDR_W+1)'(1);
        if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish on the edge where the last outstanding word is handed over,
        // so done lands in the cycle right after the out_last beat.
        if (occ == {1'b0, pop}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Contents are never reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      rvld_q     <= 1'b0;
      rdata_q    <= '0;
      raddr_q    <= '0;
      rlast_q    <= 1'b0;
      buf_data_q <= '0;
      buf_addr_q <= '0;
      buf_last_q <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      // The in-flight word is always consumed (bypassed or buffered) the
      // cycle it appears, so its valid just follows the issue strobe.
      rvld_q  <= rd_en;
      if (rd_en) begin
        rdata_q <= (bus.wr_en && bus.wr_addr == ptr_q) ? bus.wr_data : mem[ptr_q];
        raddr_q <= ptr_q;
        rlast_q <= (rem_q == (ADDR_W+1)'(1));
      end
      if (push) begin
        buf_data_q[wp_q] <= rdata_q;
        buf_addr_q[wp_q] <= raddr_q;
        buf_last_q[wp_q] <= rlast_q;
        wp_q             <= ~wp_q;
      end
      if (buf_pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, buf_pop};
    end
  end

endmodule

// File: tb/tb_alu_result_reader.sv
module tb_alu_result_reader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_reader_if #(.DATA_W(16), .ADDR_W(8)) bus ();
  alu_result_reader #(.DATA_W(16), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_mem [256];
  logic [15:0] q_data [$];
  logic [7:0]  q_addr [$];
  logic        q_last [$];
  int          q_cyc  [$];

  // Issues one command (cycle k=1 is the first cycle after acceptance),
  // collects beats, tracks hold stability during stalls, stops at done.
  task automatic run_cmd(input int start, input int count, input bit bp,
                         input int wk, input logic [7:0] wa, input logic [15:0] wd,
                         output int done_cyc, output int stable_err, output bit done_rdy);
    bit stalled;
    logic [15:0] hd; logic [7:0] ha; logic hl;
    q_data.delete(); q_addr.delete(); q_last.delete(); q_cyc.delete();
    done_cyc = -1; stable_err = 0; done_rdy = 1'b0; stalled = 1'b0;
    hd = '0; ha = '0; hl = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_start = start[7:0]; bus.cmd_count = count[8:0];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      if (bp) bus.out_ready = (((k-1) % 4 == 0) || ((k-1) % 4 == 3)) ? 1'b1 : 1'b0;
      else    bus.out_ready = 1'b1;
      bus.wr_en = (k == wk); bus.wr_addr = wa; bus.wr_data = wd;
      if (k == wk) exp_mem[wa] = wd;
      @(negedge clk);
      if (stalled && !(bus.out_valid && bus.out_data == hd && bus.out_addr == ha && bus.out_last == hl))
        stable_err++;
      stalled = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data); q_addr.push_back(bus.out_addr);
        q_last.push_back(bus.out_last); q_cyc.push_back(k);
      end else if (bus.out_valid) begin
        stalled = 1'b1; hd = bus.out_data; ha = bus.out_addr; hl = bus.out_last;
      end
      if (bus.done) begin done_cyc = k; done_rdy = bus.cmd_ready; break; end
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.cmd_valid = 0; bus.cmd_start = 0; bus.cmd_count = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 5'b0 ||
        bus.out_data !== 16'h0 || bus.out_addr !== 8'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b done=%b data=%h addr=%h, need all 0",
               bus.cmd_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data, bus.out_addr);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b, need 1 0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_addr = i[7:0]; bus.wr_data = 16'h1000 + i[15:0];
      exp_mem[i] = 16'h1000 + i[15:0];
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
  endtask

  task automatic test_basic();
    int dc, se; bit dr;
    run_cmd(0, 8, 0, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 8) begin n_err++; $display("FAIL basic_beats: got %0d, need 8", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_cmp++;
      if (q_data[i] !== 16'h1000 + i[15:0] || q_addr[i] !== i[7:0] ||
          q_last[i] !== (i == 7) || q_cyc[i] != i + 2) begin
        n_err++;
        $display("FAIL basic_beat%0d: got data=%h addr=%0d last=%b cyc=%0d, need %h %0d %b %0d",
                 i, q_data[i], q_addr[i], q_last[i], q_cyc[i], 16'h1000 + i[15:0], i, (i == 7), i + 2);
      end
    end
    n_cmp++;
    if (dc != 10 || dr !== 1'b1) begin
      n_err++; $display("FAIL basic_done: got cyc=%0d rdy=%b, need 10 1", dc, dr);
    end
  endtask

  task automatic test_wrap();
    int dc, se; bit dr;
    logic [7:0] ea [4];
    ea[0] = 8'd254; ea[1] = 8'd255; ea[2] = 8'd0; ea[3] = 8'd1;
    run_cmd(254, 4, 0, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 4) begin n_err++; $display("FAIL wrap_beats: got %0d, need 4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_cmp++;
      if (q_addr[i] !== ea[i] || q_data[i] !== exp_mem[ea[i]] || q_last[i] !== (i == 3)) begin
        n_err++;
        $display("FAIL wrap_beat%0d: got addr=%0d data=%h last=%b, need %0d %h %b",
                 i, q_addr[i], q_data[i], q_last[i], ea[i], exp_mem[ea[i]], (i == 3));
      end
    end
    n_cmp++;
    if (dc != 6) begin n_err++; $display("FAIL wrap_done: got cyc=%0d, need 6", dc); end
  endtask

  task automatic test_backpressure();
    int dc, se; bit dr;
    run_cmd(20, 6, 1, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 6) begin n_err++; $display("FAIL bp_beats: got %0d, need 6", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 6; i++) begin
      n_cmp++;
      if (q_addr[i] !== 8'(20 + i) || q_data[i] !== exp_mem[20 + i] || q_last[i] !== (i == 5)) begin
        n_err++;
        $display("FAIL bp_beat%0d: got addr=%0d data=%h last=%b, need %0d %h %b",
                 i, q_addr[i], q_data[i], q_last[i], 20 + i, exp_mem[20 + i], (i == 5));
      end
    end
    n_cmp++;
    if (se != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls, need 0", se); end
    n_cmp++;
    if (dc < 0) begin n_err++; $display("FAIL bp_done: got no done, need done"); end
  endtask

  task automatic test_same_cycle();
    int dc, se; bit dr;
    run_cmd(0, 8, 0, 6, 8'd5, 16'hBEEF, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 8) begin n_err++; $display("FAIL wf_beats: got %0d, need 8", q_data.size()); end
    else begin
      n_cmp++;
      if (q_data[5] !== 16'hBEEF || q_addr[5] !== 8'd5) begin
        n_err++; $display("FAIL wf_addr5: got data=%h addr=%0d, need beef 5", q_data[5], q_addr[5]);
      end
      n_cmp++;
      if (q_data[4] !== 16'h1004) begin
        n_err++; $display("FAIL wf_addr4: got %h, need 1004", q_data[4]);
      end
    end
  endtask

  task automatic test_count0();
    int dc, se; bit dr;
    run_cmd(7, 0, 0, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 0 || dc != 1 || dr !== 1'b1) begin
      n_err++; $display("FAIL count0: got beats=%0d done_cyc=%0d rdy=%b, need 0 1 1", q_data.size(), dc, dr);
    end
  endtask

  task automatic test_count256();
    int dc, se, bad; bit dr;
    run_cmd(100, 256, 0, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 256) begin n_err++; $display("FAIL c256_beats: got %0d, need 256", q_data.size()); end
    bad = 0;
    for (int i = 0; i < q_data.size() && i < 256; i++)
      if (q_addr[i] !== 8'(100 + i) || q_data[i] !== exp_mem[(100 + i) % 256] ||
          q_last[i] !== (i == 255) || q_cyc[i] != i + 2) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL c256_content: got %0d bad beats, need 0", bad); end
    n_cmp++;
    if (q_addr.size() == 256 && q_addr[255] !== 8'd99) begin
      n_err++; $display("FAIL c256_last_addr: got %0d, need 99", q_addr[255]);
    end
    n_cmp++;
    if (dc != 258) begin n_err++; $display("FAIL c256_done: got cyc=%0d, need 258", dc); end
  endtask

  task automatic test_reset_mid();
    int beats, dones, dc, se; bit dr;
    beats = 0; dones = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_start = 8'd0; bus.cmd_count = 9'd8;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) beats++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (beats != 3) begin n_err++; $display("FAIL rmid_pre_beats: got %0d, need 3", beats); end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL rmid_flush: got vld=%b busy=%b done=%b, need 0 0 0", bus.out_valid, bus.busy, bus.done);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.out_valid) dones++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones != 0) begin n_err++; $display("FAIL rmid_no_done: got %0d done/valid cycles, need 0", dones); end
    run_cmd(10, 4, 0, 0, 8'd0, 16'd0, dc, se, dr);
    n_cmp++;
    if (q_data.size() != 4 || dc != 6) begin
      n_err++; $display("FAIL rmid_next_cmd: got beats=%0d done_cyc=%0d, need 4 6", q_data.size(), dc);
    end else begin
      n_cmp++;
      if (q_addr[0] !== 8'd10 || q_data[3] !== exp_mem[13] || q_last[3] !== 1'b1) begin
        n_err++; $display("FAIL rmid_next_data: got addr0=%0d data3=%h last3=%b, need 10 %h 1",
                          q_addr[0], q_data[3], q_last[3], exp_mem[13]);
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_wrap();
    test_backpressure();
    test_same_cycle();
    test_count0();
    test_count256();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
